// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock supervisor, clocked from the free-running reference.
// Releases sys_rst_n only after the synchronised lock flag has been stable long enough.
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       clear_fault,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_LAST   = 2'(MAX_RETRIES - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] timer_reg, timer_next;
    logic [1:0]       retry_reg, retry_next;
    logic [7:0]       loss_reg, loss_next;
    logic [1:0]       sync_reg;
    logic             lk;
    logic             pll_rst_reg, sys_rst_n_reg, ready_reg, fault_reg;

    // pll_locked comes from the PLL's own domain; only the second flop is used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], pll_locked};
        end
    end

    assign lk = sync_reg[1];

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg + 1'b1;
        retry_next = retry_reg;
        loss_next  = loss_reg;
        case (state_reg)
            PLL_RST: begin
                if (timer_reg == RST_LAST) begin
                    state_next = WAIT_LOCK;
                    timer_next = '0;
                end
            end
            WAIT_LOCK: begin
                // Lock takes priority over a timeout on the same cycle.
                if (lk) begin
                    state_next = STABLE;
                    timer_next = '0;
                end else if (timer_reg == TIMEOUT_LAST) begin
                    timer_next = '0;
                    if (retry_reg == RETRY_LAST) begin
                        state_next = FAULT;
                    end else begin
                        state_next = PLL_RST;
                        if (retry_reg != 2'd3) begin
                            retry_next = retry_reg + 2'd1;
                        end
                    end
                end
            end
            STABLE: begin
                if (!lk) begin
                    state_next = WAIT_LOCK;
                    timer_next = '0;
                end else if (timer_reg == STABLE_LAST) begin
                    state_next = RUN;
                    timer_next = '0;
                end
            end
            RUN: begin
                timer_next = '0;
                if (!lk) begin
                    state_next = PLL_RST;
                    retry_next = 2'd0;
                    if (loss_reg != 8'hFF) begin
                        loss_next = loss_reg + 8'd1;
                    end
                end
            end
            FAULT: begin
                timer_next = '0;
                if (clear_fault) begin
                    state_next = PLL_RST;
                    retry_next = 2'd0;
                end
            end
            default: begin
                state_next = PLL_RST;
                timer_next = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the entering edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= PLL_RST;
            timer_reg     <= '0;
            retry_reg     <= 2'd0;
            loss_reg      <= 8'd0;
            pll_rst_reg   <= 1'b1;
            sys_rst_n_reg <= 1'b0;
            ready_reg     <= 1'b0;
            fault_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            retry_reg     <= retry_next;
            loss_reg      <= loss_next;
            pll_rst_reg   <= (state_next == PLL_RST) || (state_next == FAULT);
            sys_rst_n_reg <= (state_next == RUN);
            ready_reg     <= (state_next == RUN);
            fault_reg     <= (state_next == FAULT);
        end
    end

    assign pll_rst       = pll_rst_reg;
    assign sys_rst_n     = sys_rst_n_reg;
    assign ready         = ready_reg;
    assign fault         = fault_reg;
    assign retry_cnt     = retry_reg;
    assign lock_loss_cnt = loss_reg;

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Sequences the 50 MHz-referenced RF-link PLL: drives the PLL reset, watches its lock flag, and releases downstream logic only after lock has been stable for a programmable time.
- Runs on the free-running 50 MHz board reference, never on a PLL output, so it keeps working while the PLL is unlocked.
- On lock loss it re-asserts the downstream reset and re-runs the PLL reset sequence. After a bounded number of failed attempts it raises a sticky fault.

Parameters:
- RST_CYCLES, 16, width of the pll_rst pulse in clk cycles (must be ≥1).
- LOCK_TIMEOUT, 50000, cycles to wait for lock after pll_rst deasserts (1 ms at 50 MHz).
- STABLE_CYCLES, 1024, consecutive locked cycles required before releasing sys_rst_n.
- MAX_RETRIES, 3, failed lock attempts allowed before FAULT.
- CNT_W, 16, width of the internal timer; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- clk  in  1  50 MHz reference clock, same net as the PLL refclk.
- rst_n  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL locked flag; asynchronous to clk.
- clear_fault  in  1  single-cycle pulse; leaves FAULT and restarts the sequence.
- pll_rst  out  1  active-high PLL reset.
- sys_rst_n  out  1  active-low reset for downstream logic (outclk domains re-synchronise it locally).
- ready  out  1  high in RUN.
- fault  out  1  high in FAULT.
- retry_cnt  out  2  failed attempts in the current sequence, saturating at 3.
- lock_loss_cnt  out  8  lock losses seen while in RUN, saturating at 255.

Behaviour:
- pll_locked passes through a 2-flop synchroniser; lk denotes the synchronised value (2-cycle latency). All decisions use lk only.
- Reset (rst_n low, async):
  - State = PLL_RST, timer = 0.
  - pll_rst = 1, sys_rst_n = 0, ready = 0, fault = 0, retry_cnt = 0, lock_loss_cnt = 0.
  - Synchroniser flops cleared to 0.
- PLL_RST:
  - pll_rst = 1; timer counts up.
  - When timer reaches RST_CYCLES-1: go to WAIT_LOCK, timer = 0.
  - pll_rst is therefore high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - pll_rst = 0; timer counts up.
  - If lk = 1: go to STABLE, timer = 0.
  - Else if timer = LOCK_TIMEOUT-1:
    - If retry_cnt = MAX_RETRIES-1: go to FAULT.
    - Otherwise: retry_cnt += 1, go to PLL_RST.
- STABLE:
  - timer counts consecutive lk = 1 cycles.
  - lk = 0 → return to WAIT_LOCK, timer = 0. The lock timeout restarts; this does not count as a retry.
  - Timer = STABLE_CYCLES-1 with lk = 1 → go to RUN.
- RUN:
  - sys_rst_n = 1, ready = 1. sys_rst_n rises on the clock edge that enters RUN.
  - lk = 0 → next cycle: sys_rst_n = 0, ready = 0, lock_loss_cnt += 1 (saturating), retry_cnt = 0, go to PLL_RST.
- FAULT:
  - pll_rst = 1 (PLL held in reset), sys_rst_n = 0, fault = 1. Stays here regardless of lk.
  - clear_fault → go to PLL_RST, retry_cnt = 0, fault = 0. lock_loss_cnt is preserved.
- clear_fault is ignored in every state other than FAULT.
- sys_rst_n = 0 in every state except RUN. ready and fault are never high together.
- Simultaneous events:
  - In WAIT_LOCK, lk = 1 on the timeout cycle → lock wins; go to STABLE.
  - In STABLE, lk = 0 on the final count cycle → lock-drop wins; go to WAIT_LOCK.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- rst_n asserted in any state returns immediately to reset values.

Test Plan:
- Normal lock:
  - Stimulus: release rst_n; hold pll_locked = 0; raise pll_locked 100 cycles after pll_rst falls.
  - Required: pll_rst high exactly 16 cycles. sys_rst_n/ready rise 2+1024 cycles after pll_locked rises (±1 for the state-transition edge). retry_cnt = 0.
- Glitch during stable:
  - Stimulus: lock, then drop pll_locked for 3 cycles at STABLE count 500, then re-raise.
  - Required: STABLE restarts; sys_rst_n rises 1024 cycles after the re-lock; pll_rst never re-asserted.
- Retry and fault:
  - Stimulus: keep pll_locked = 0.
  - Required: three 16-cycle pll_rst pulses spaced by 50000 cycles; retry_cnt steps 0→1→2; then fault = 1 and pll_rst held high.
  - Follow-up: pulse clear_fault with pll_locked = 1. Required: fault = 0, retry_cnt = 0, new 16-cycle pulse, then normal lock.
- Lock loss in RUN:
  - Stimulus: reach RUN, then drop pll_locked.
  - Required: sys_rst_n = 0 and ready = 0 within 3 cycles; lock_loss_cnt = 1; a new pll_rst pulse of 16 cycles. Repeat 300 times → lock_loss_cnt saturates at 255.
- Async reset mid-sequence:
  - Stimulus: assert rst_n low during STABLE and again during FAULT.
  - Required: outputs take reset values without waiting for a clk edge; all counters cleared.
- Boundary tie:
  - Stimulus: pll_locked arranged so lk rises exactly on WAIT_LOCK timer = 49999.
  - Required: enter STABLE; retry_cnt unchanged.
